// File: rtl/timer_multi_core.sv
// Multi-channel timer core: NUM_CH independent up/down counters sharing one
// programmable prescaler, with one-shot/periodic modes and sticky maskable interrupts.
module timer_multi_core #(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [PRESC_W-1:0]        presc_div,
    input  logic [NUM_CH-1:0]         start,
    input  logic [NUM_CH-1:0]         stop,
    input  logic [NUM_CH-1:0]         mode_periodic,
    input  logic [NUM_CH-1:0]         dir_down,
    input  logic [NUM_CH*WIDTH-1:0]   load_val,
    input  logic [NUM_CH-1:0]         irq_en,
    input  logic [NUM_CH-1:0]         irq_clr,
    output logic [NUM_CH*WIDTH-1:0]   cur_count,
    output logic [NUM_CH-1:0]         running,
    output logic [NUM_CH-1:0]         irq_pend,
    output logic                      irq
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_t;

    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;

    // >= rather than == so a divider lowered mid-period still produces a tick
    assign tick = (presc_cnt >= presc_div);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_t          st_q, st_d;
        logic [WIDTH-1:0]   cnt_q, cnt_d;
        logic [WIDTH-1:0]   lv, init;
        logic               pend_q, pend_d;
        logic               term;

        assign lv   = load_val[i*WIDTH +: WIDTH];
        assign init = dir_down[i] ? lv : '0;
        assign term = dir_down[i] ? (cnt_q == '0) : (cnt_q == lv);

        // stop beats start, start beats a tick; a terminal event beats irq_clr
        always_comb begin
            st_d   = st_q;
            cnt_d  = cnt_q;
            pend_d = pend_q & ~irq_clr[i];
            if (stop[i]) begin
                st_d = IDLE;
            end else if (start[i]) begin
                st_d  = RUN;
                cnt_d = init;
            end else if (st_q == RUN && tick) begin
                if (term) begin
                    pend_d = 1'b1;
                    if (mode_periodic[i]) begin
                        cnt_d = init;
                    end else begin
                        st_d = IDLE;
                    end
                end else if (dir_down[i]) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rstn) begin
                st_q   <= IDLE;
                cnt_q  <= '0;
                pend_q <= 1'b0;
            end else begin
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                pend_q <= pend_d;
            end
        end

        assign cur_count[i*WIDTH +: WIDTH] = cnt_q;
        assign running[i]                  = (st_q == RUN);
        assign irq_pend[i]                 = pend_q;
    end

    // Output stage: irq lags irq_pend by one cycle
    always_ff @(posedge clk) begin
        if (!rstn) begin
            irq <= 1'b0;
        end else begin
            irq <= |(irq_pend & irq_en);
        end
    end

endmodule
